// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: instruction-fetch stage with PC register, instruction
// memory and a cycle-counted bubble sequencer. Loads, stores and branches are
// followed by a fixed number of NOP bubbles. A redirect from execute flushes
// the stage and restarts fetch at the branch target.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | fetch mem[pc] each enabled cycle, advance pc by 4
// BUBBLE  | emit NOPs, pc frozen, count down the remaining bubble cycles
module fetch_stall_unit #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_STALL = 3,
    parameter int          BR_STALL  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [31:0]       instr_pc,
    output logic [31:0]       pc,
    output logic [2:0]        pc_inc,
    output logic              stalling
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    // Stall counts live in a 4-bit counter; a zero count disables the bubble.
    localparam logic [3:0] MEM_STALL_CNT = 4'(MEM_STALL);
    localparam logic [3:0] BR_STALL_CNT  = 4'(BR_STALL);
    localparam bit         MEM_STALL_EN  = (MEM_STALL > 0);
    localparam bit         BR_STALL_EN   = (BR_STALL > 0);

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_idx;
    logic [DATA_W-1:0]   rd_data;
    logic [5:0]          rd_opcode;
    logic                is_mem_op;
    logic                is_branch;
    logic                advance;

    // Fetch index ignores the byte offset and the upper PC bits, so fetch
    // wraps modulo the memory depth.
    assign rd_idx    = pc_q[ADDR_W+1:2];
    assign rd_data   = mem[rd_idx];
    assign rd_opcode = rd_data[31:26];
    assign is_mem_op = (rd_opcode == OP_LW) || (rd_opcode == OP_SW);
    assign is_branch = (rd_opcode == OP_BEQ);
    assign advance   = (state_q == ST_FETCH) && fetch_en && !redirect_valid;

    // Program-load port; the asynchronous read above sees the pre-write word
    // in the cycle of the write, giving read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state logic: redirect beats hold, hold beats the state action.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;

        if (redirect_valid) begin
            pc_d          = redirect_pc;
            state_d       = ST_FETCH;
            cnt_d         = 4'd0;
            instr_d       = '0;
            instr_valid_d = 1'b0;
        end else if (fetch_en) begin
            case (state_q)
                ST_FETCH: begin
                    instr_d       = rd_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    if (is_mem_op && MEM_STALL_EN) begin
                        cnt_d   = MEM_STALL_CNT;
                        state_d = ST_BUBBLE;
                    end else if (is_branch && BR_STALL_EN) begin
                        cnt_d   = BR_STALL_CNT;
                        state_d = ST_BUBBLE;
                    end
                end
                ST_BUBBLE: begin
                    instr_d       = '0;
                    instr_valid_d = 1'b0;
                    cnt_d         = cnt_q - 4'd1;
                    // A count of 0 cannot occur here, but treat it like the
                    // last bubble so the FSM can never get stuck.
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset; memory is untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            cnt_q         <= 4'd0;
            pc_q          <= RESET_PC;
            instr_pc_q    <= 32'h0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Combinational status outputs.
    always_comb begin
        pc_inc   = advance ? 3'd4 : 3'd0;
        stalling = (state_q == ST_BUBBLE);
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Directed testbench for fetch_stall_unit (ADDR_W=8, MEM_STALL=3, BR_STALL=1).
module tb_fetch_stall_unit;

    localparam logic [31:0] W_ADD = 32'h00018020;
    localparam logic [31:0] W_LW  = 32'h8C020000;
    localparam logic [31:0] W_BEQ = 32'h10000004;
    localparam logic [31:0] W_A   = 32'hABCD0001;
    localparam logic [31:0] W_B   = 32'h5A5A0002;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic [2:0]  pc_inc;
    logic        stalling;

    int n_cmp;
    int n_bad;

    fetch_stall_unit #(
        .ADDR_W(8), .DATA_W(32), .RESET_PC(32'h0), .MEM_STALL(3), .BR_STALL(1)
    ) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .pc(pc), .pc_inc(pc_inc), .stalling(stalling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        prog_we = 1'b0; prog_addr = 8'h0; prog_data = 32'h0;
        for (int i = 0; i < 256; i++) load_word(8'(i), W_ADD);
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %b/%h want 0/0", instr_valid, instr); end
        n_cmp++; if (instr_pc !== 32'h0 || pc_inc !== 3'd0 || stalling !== 1'b0) begin n_bad++; $display("FAIL reset_misc: got %h/%0d/%b want 0/0/0", instr_pc, pc_inc, stalling); end
        reset = 1'b0; fetch_en = 1'b1;
        #1;
        n_cmp++; if (pc_inc !== 3'd4) begin n_bad++; $display("FAIL first_pc_inc: got %0d want 4", pc_inc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4*i) || instr !== W_ADD) begin n_bad++; $display("FAIL seq_fetch%0d: got %b/%h/%h want 1/%h/%h", i, instr_valid, instr_pc, instr, 32'(4*i), W_ADD); end
            n_cmp++; if (pc !== 32'(4*i+4) || pc_inc !== 3'd4) begin n_bad++; $display("FAIL seq_pc%0d: got %h/%0d want %h/4", i, pc, pc_inc, 32'(4*i+4)); end
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (pc !== 32'h0 || instr_valid !== 1'b0 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL async_reset: got %h/%b/%h want 0/0/0", pc, instr_valid, instr_pc); end
        fetch_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_stall();
        load_word(8'd1, W_LW);
        fetch_en = 1'b1;
        tick();
        tick();
        n_cmp++; if (instr !== W_LW || instr_pc !== 32'h4 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL lw_fetch: got %h/%h/%b want %h/4/1", instr, instr_pc, instr_valid, W_LW); end
        n_cmp++; if (stalling !== 1'b1 || pc_inc !== 3'd0 || pc !== 32'h8) begin n_bad++; $display("FAIL lw_enter_bubble: got %b/%0d/%h want 1/0/8", stalling, pc_inc, pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (instr !== 32'h0 || instr_valid !== 1'b0 || instr_pc !== 32'h4 || pc !== 32'h8) begin n_bad++; $display("FAIL lw_bubble%0d: got %h/%b/%h/%h want 0/0/4/8", i, instr, instr_valid, instr_pc, pc); end
            n_cmp++; if (stalling !== (i < 2)) begin n_bad++; $display("FAIL lw_stalling%0d: got %b want %b", i, stalling, (i < 2)); end
        end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || pc !== 32'hC) begin n_bad++; $display("FAIL lw_resume: got %b/%h/%h want 1/8/c", instr_valid, instr_pc, pc); end
    endtask

    task automatic test_branch_redirect();
        fetch_en = 1'b0;
        load_word(8'd2, W_BEQ);
        fetch_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        #1;
        n_cmp++; if (pc_inc !== 3'd0) begin n_bad++; $display("FAIL redirect_pc_inc: got %0d want 0", pc_inc); end
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 32'h8 || instr_valid !== 1'b0 || instr !== 32'h0) begin n_bad++; $display("FAIL redirect_flush: got %h/%b/%h want 8/0/0", pc, instr_valid, instr); end
        tick();
        n_cmp++; if (instr !== W_BEQ || instr_pc !== 32'h8 || stalling !== 1'b1) begin n_bad++; $display("FAIL beq_fetch: got %h/%h/%b want %h/8/1", instr, instr_pc, stalling, W_BEQ); end
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || stalling !== 1'b0 || pc !== 32'hC) begin n_bad++; $display("FAIL beq_bubble: got %b/%b/%h want 0/0/c", instr_valid, stalling, pc); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin n_bad++; $display("FAIL beq_resume: got %b/%h want 1/c", instr_valid, instr_pc); end
        do_redirect(32'h8);
        tick();
        n_cmp++; if (stalling !== 1'b1) begin n_bad++; $display("FAIL beq2_stall: got %b want 1", stalling); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        n_cmp++; if (pc_inc !== 3'd0 || stalling !== 1'b1) begin n_bad++; $display("FAIL redirect_in_bubble: got %0d/%b want 0/1", pc_inc, stalling); end
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 32'h40 || stalling !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL redirect_target: got %h/%b/%b want 40/0/0", pc, stalling, instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || pc !== 32'h44) begin n_bad++; $display("FAIL redirect_fetch: got %b/%h/%h want 1/40/44", instr_valid, instr_pc, pc); end
    endtask

    task automatic test_fetch_hold();
        do_redirect(32'h4);
        tick();
        tick();
        fetch_en = 1'b0;
        #1;
        n_cmp++; if (pc_inc !== 3'd0) begin n_bad++; $display("FAIL hold_pc_inc: got %0d want 0", pc_inc); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (stalling !== 1'b1 || pc !== 32'h8 || instr_valid !== 1'b0 || instr_pc !== 32'h4) begin n_bad++; $display("FAIL hold%0d: got %b/%h/%b/%h want 1/8/0/4", i, stalling, pc, instr_valid, instr_pc); end
        end
        fetch_en = 1'b1;
        tick();
        n_cmp++; if (stalling !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL hold_bubble2: got %b/%b want 1/0", stalling, instr_valid); end
        tick();
        n_cmp++; if (stalling !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL hold_bubble3: got %b/%b want 0/0", stalling, instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin n_bad++; $display("FAIL hold_resume: got %b/%h want 1/8", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap_prog();
        fetch_en = 1'b0;
        load_word(8'd255, W_A);
        fetch_en = 1'b1;
        do_redirect(32'h3FC);
        tick();
        n_cmp++; if (instr !== W_A || instr_pc !== 32'h3FC || pc !== 32'h400) begin n_bad++; $display("FAIL wrap_255: got %h/%h/%h want %h/3fc/400", instr, instr_pc, pc, W_A); end
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = W_B;
        tick();
        prog_we = 1'b0;
        n_cmp++; if (instr !== W_ADD || instr_pc !== 32'h400) begin n_bad++; $display("FAIL rbw_old: got %h/%h want %h/400", instr, instr_pc, W_ADD); end
        do_redirect(32'h400);
        tick();
        n_cmp++; if (instr !== W_B || instr_pc !== 32'h400) begin n_bad++; $display("FAIL rbw_new: got %h/%h want %h/400", instr, instr_pc, W_B); end
        do_redirect(32'hFFFF_FFFC);
        tick();
        n_cmp++; if (instr !== W_A || pc !== 32'h0) begin n_bad++; $display("FAIL pc_wrap32: got %h/%h want %h/0", instr, pc, W_A); end
    endtask

    task automatic test_back_to_back();
        fetch_en = 1'b0;
        load_word(8'd2, W_LW);
        fetch_en = 1'b1;
        do_redirect(32'h4);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (instr !== W_LW || instr_pc !== 32'(4 + 4*k) || stalling !== 1'b1) begin n_bad++; $display("FAIL b2b_lw%0d: got %h/%h/%b want %h/%h/1", k, instr, instr_pc, stalling, W_LW, 32'(4 + 4*k)); end
            for (int i = 0; i < 3; i++) begin
                tick();
                n_cmp++; if (instr_valid !== 1'b0 || pc !== 32'(8 + 4*k)) begin n_bad++; $display("FAIL b2b_bubble%0d_%0d: got %b/%h want 0/%h", k, i, instr_valid, pc, 32'(8 + 4*k)); end
            end
        end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin n_bad++; $display("FAIL b2b_resume: got %b/%h want 1/c", instr_valid, instr_pc); end
    endtask

    task automatic test_reset_mid_bubble();
        do_redirect(32'h4);
        tick();
        tick();
        n_cmp++; if (stalling !== 1'b1) begin n_bad++; $display("FAIL midbub_pre: got %b want 1", stalling); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (stalling !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL midbub_reset: got %b/%h/%b want 0/0/0", stalling, pc, instr_valid); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || stalling !== 1'b0 || pc !== 32'h4) begin n_bad++; $display("FAIL midbub_after: got %b/%h/%b/%h want 1/0/0/4", instr_valid, instr_pc, stalling, pc); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load_stall();
        test_branch_redirect();
        test_fetch_hold();
        test_wrap_prog();
        test_back_to_back();
        test_reset_mid_bubble();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
